// File: rtl/scale_op_sequencer.sv
// Command sequencer for the scaling ALU: accepts one command at a time, optionally clears the
// framebuffer, runs the ALU under a done-mask and watchdog, and owns the framebuffer write port.
module scale_op_sequencer #(
    parameter logic [3:0] IDLE_SEL       = 4'b0111,
    parameter int         FB_WORDS       = 307200,
    parameter logic [7:0] BG_COLOR       = 8'h00,
    parameter int         SETTLE_CYCLES  = 2,
    parameter int         DONE_MASK      = 4,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_clear,
    input  logic        cmd_abort,
    output logic        cmd_ready,
    output logic [3:0]  alu_seletor,
    input  logic [18:0] alu_ram_wraddr,
    input  logic [7:0]  alu_ram_data,
    input  logic        alu_ram_wren,
    input  logic        alu_done,
    output logic [18:0] ram_wraddr,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done_pulse,
    output logic        error,
    output logic [3:0]  last_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_FINISH
    } state_t;

    localparam logic [18:0] FB_LAST     = 19'(FB_WORDS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [21:0] MASK_CNT    = 22'(DONE_MASK);
    localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  alu_seletor_q, alu_seletor_d;
    logic [18:0] ram_wraddr_q, ram_wraddr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        ram_wren_q, ram_wren_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        done_pulse_q, done_pulse_d;
    logic        error_q, error_d;
    logic [3:0]  last_op_q, last_op_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [21:0] run_cnt_q, run_cnt_d;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b1010, 4'b1011: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        alu_seletor_d = IDLE_SEL;
        ram_wraddr_d  = ram_wraddr_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        done_pulse_d  = 1'b0;
        error_d       = 1'b0;
        last_op_d     = last_op_q;
        settle_cnt_d  = settle_cnt_q;
        run_cnt_d     = run_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    last_op_d = cmd_op;
                    if (!op_legal(cmd_op)) begin
                        error_d = 1'b1;
                    end else if (cmd_clear) begin
                        state_d      = S_CLEAR;
                        ram_wraddr_d = '0;
                        ram_data_d   = BG_COLOR;
                        ram_wren_d   = 1'b1;
                    end else begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end
            S_CLEAR: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else if (ram_wraddr_q == FB_LAST) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                end else begin
                    ram_wraddr_d = ram_wraddr_q + 19'd1;
                    ram_data_d   = BG_COLOR;
                    ram_wren_d   = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d       = S_RUN;
                    run_cnt_d     = '0;
                    alu_seletor_d = last_op_q;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                // Priority is abort, then done, then watchdog; the ALU write seen on the
                // done cycle is still forwarded so it lands during FINISH.
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else if ((run_cnt_q >= MASK_CNT) && alu_done) begin
                    state_d      = S_FINISH;
                    done_pulse_d = 1'b1;
                    ram_wraddr_d = alu_ram_wraddr;
                    ram_data_d   = alu_ram_data;
                    ram_wren_d   = alu_ram_wren;
                end else if (run_cnt_q == TIMEOUT_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    run_cnt_d     = run_cnt_q + 22'd1;
                    alu_seletor_d = last_op_q;
                    ram_wraddr_d  = alu_ram_wraddr;
                    ram_data_d    = alu_ram_data;
                    ram_wren_d    = alu_ram_wren;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            alu_seletor_q <= IDLE_SEL;
            ram_wraddr_q  <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            done_pulse_q  <= 1'b0;
            error_q       <= 1'b0;
            last_op_q     <= '0;
            settle_cnt_q  <= '0;
            run_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            alu_seletor_q <= alu_seletor_d;
            ram_wraddr_q  <= ram_wraddr_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            busy_q        <= busy_d;
            cmd_ready_q   <= cmd_ready_d;
            done_pulse_q  <= done_pulse_d;
            error_q       <= error_d;
            last_op_q     <= last_op_d;
            settle_cnt_q  <= settle_cnt_d;
            run_cnt_q     <= run_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_seletor = alu_seletor_q;
    assign ram_wraddr  = ram_wraddr_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;
    assign done_pulse  = done_pulse_q;
    assign error       = error_q;
    assign last_op     = last_op_q;

endmodule
